// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encodings and control vectors for the pipeline stall controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Which output encoding is shown this cycle; Stall and Hold share a vector,
  // so the kind is kept separately for the performance counters.
  typedef enum logic [1:0] {
    OUT_NORMAL,
    OUT_STALL,
    OUT_HOLD,
    OUT_FLUSH
  } out_kind_e;

  // {PCWrite, IFIDWrite, IDStall, IF_Flush}
  localparam logic [3:0] CTRL_NORMAL = 4'b1100;
  localparam logic [3:0] CTRL_STALL  = 4'b0010;
  localparam logic [3:0] CTRL_HOLD   = 4'b0010;
  localparam logic [3:0] CTRL_FLUSH  = 4'b1111;

  localparam int DEF_MAX_STALL = 3;

  function automatic logic [3:0] ctrl_vec(input out_kind_e kind);
    case (kind)
      OUT_STALL: ctrl_vec = CTRL_STALL;
      OUT_HOLD:  ctrl_vec = CTRL_HOLD;
      OUT_FLUSH: ctrl_vec = CTRL_FLUSH;
      default:   ctrl_vec = CTRL_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// rtl/pipeline_stall_controller_if.sv - hazard request / pipeline control bundle; STALL_PERF_CNT_EN adds counter outputs
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 2
);
  logic             StallReq;
  logic [CNT_W-1:0] StallCycles;
  logic             FlushReq;
  logic             BusyReq;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDStall;
  logic             IF_Flush;
  logic [1:0]       State;
`ifdef STALL_PERF_CNT_EN
  logic [31:0]      StallCount;
  logic [31:0]      HoldCount;
  logic [31:0]      FlushCount;

  modport master (
    output StallReq, StallCycles, FlushReq, BusyReq,
    input  PCWrite, IFIDWrite, IDStall, IF_Flush, State,
    input  StallCount, HoldCount, FlushCount
  );

  modport slave (
    input  StallReq, StallCycles, FlushReq, BusyReq,
    output PCWrite, IFIDWrite, IDStall, IF_Flush, State,
    output StallCount, HoldCount, FlushCount
  );
`else
  modport master (
    output StallReq, StallCycles, FlushReq, BusyReq,
    input  PCWrite, IFIDWrite, IDStall, IF_Flush, State
  );

  modport slave (
    input  StallReq, StallCycles, FlushReq, BusyReq,
    output PCWrite, IFIDWrite, IDStall, IF_Flush, State
  );
`endif
endinterface

// File: rtl/sat_counter32.sv
// rtl/sat_counter32.sv - 32-bit saturating event counter with synchronous reset and preset load
module sat_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - owner of PCWrite/IFIDWrite/IDStall/IF_Flush; STALL_PERF_CNT_EN adds event counters
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_STALL = DEF_MAX_STALL,
  parameter int CNT_W     = 2
) (
  input logic                        Clk,
  input logic                        Reset,
  pipeline_stall_controller_if.slave ctrl
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_STALL);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           state, nxt_state;
  logic [CNT_W-1:0] remaining, nxt_remaining;
  logic             pend_flush, nxt_pend_flush;
  out_kind_e        kind;
  logic [CNT_W-1:0] stall_len;

  always_comb begin
    stall_len = (ctrl.StallCycles == '0) ? ONE : ctrl.StallCycles;
    if (stall_len > MAX_LEN) stall_len = MAX_LEN;
  end

  // Busy wins over everything, then flush; a HOLD with remaining count resumes
  // the stall, otherwise HOLD falls through to the IDLE rules in the same cycle.
  always_comb begin
    nxt_state      = state;
    nxt_remaining  = remaining;
    nxt_pend_flush = pend_flush;
    kind           = OUT_NORMAL;
    if (Reset) begin
      kind = OUT_NORMAL;
    end else if (ctrl.BusyReq) begin
      kind      = OUT_HOLD;
      nxt_state = HOLD;
      if (ctrl.FlushReq) nxt_pend_flush = 1'b1;
    end else if (ctrl.FlushReq || pend_flush) begin
      kind           = OUT_FLUSH;
      nxt_pend_flush = 1'b0;
      nxt_remaining  = '0;
      nxt_state      = IDLE;
    end else if ((state != IDLE) && (remaining != '0)) begin
      kind = OUT_STALL;
      if (remaining == ONE) begin
        nxt_remaining = '0;
        nxt_state     = IDLE;
      end else begin
        nxt_remaining = remaining - ONE;
        nxt_state     = STALL;
      end
    end else if (ctrl.StallReq) begin
      kind = OUT_STALL;
      if (stall_len > ONE) begin
        nxt_remaining = stall_len - ONE;
        nxt_state     = STALL;
      end else begin
        nxt_state = IDLE;
      end
    end else begin
      nxt_state = IDLE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      remaining  <= '0;
      pend_flush <= 1'b0;
    end else begin
      state      <= nxt_state;
      remaining  <= nxt_remaining;
      pend_flush <= nxt_pend_flush;
    end
  end

  assign {ctrl.PCWrite, ctrl.IFIDWrite, ctrl.IDStall, ctrl.IF_Flush} = ctrl_vec(kind);
  assign ctrl.State = state;

`ifdef STALL_PERF_CNT_EN
  sat_counter32 u_stall_cnt (
    .clk        (Clk),
    .rst        (Reset),
    .en         (kind == OUT_STALL),
    .load       (1'b0),
    .load_value (32'd0),
    .count      (ctrl.StallCount)
  );

  sat_counter32 u_hold_cnt (
    .clk        (Clk),
    .rst        (Reset),
    .en         (kind == OUT_HOLD),
    .load       (1'b0),
    .load_value (32'd0),
    .count      (ctrl.HoldCount)
  );

  sat_counter32 u_flush_cnt (
    .clk        (Clk),
    .rst        (Reset),
    .en         (kind == OUT_FLUSH),
    .load       (1'b0),
    .load_value (32'd0),
    .count      (ctrl.FlushCount)
  );
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed bench for pipeline_stall_controller and sat_counter32
module tb_pipeline_stall_controller;

  localparam logic [3:0] V_N = 4'b1100;
  localparam logic [3:0] V_S = 4'b0010;
  localparam logic [3:0] V_F = 4'b1111;

  logic Clk = 1'b0;
  logic Reset;
  int   compared   = 0;
  int   mismatched = 0;

  logic        sc_en;
  logic        sc_load;
  logic [31:0] sc_load_value;
  logic [31:0] sc_count;

  always #5 Clk = ~Clk;

  pipeline_stall_controller_if #(.CNT_W(2)) if1 ();
  pipeline_stall_controller_if #(.CNT_W(2)) if2 ();

  pipeline_stall_controller #(.MAX_STALL(3), .CNT_W(2)) u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .ctrl  (if1)
  );

  pipeline_stall_controller #(.MAX_STALL(2), .CNT_W(2)) u_dut_max2 (
    .Clk   (Clk),
    .Reset (Reset),
    .ctrl  (if2)
  );

  sat_counter32 u_sat (
    .clk        (Clk),
    .rst        (Reset),
    .en         (sc_en),
    .load       (sc_load),
    .load_value (sc_load_value),
    .count      (sc_count)
  );

  function automatic logic [5:0] o1();
    return {if1.PCWrite, if1.IFIDWrite, if1.IDStall, if1.IF_Flush, if1.State};
  endfunction

  function automatic logic [5:0] o2();
    return {if2.PCWrite, if2.IFIDWrite, if2.IDStall, if2.IF_Flush, if2.State};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after the rising edge, then sit at the falling edge for checks.
  task automatic step(input logic rst, input logic sr, input logic [1:0] sc,
                      input logic fr, input logic br);
    @(posedge Clk);
    #1;
    Reset           = rst;
    if1.StallReq    = sr;
    if1.StallCycles = sc;
    if1.FlushReq    = fr;
    if1.BusyReq     = br;
    if2.StallReq    = sr;
    if2.StallCycles = sc;
    if2.FlushReq    = fr;
    if2.BusyReq     = br;
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1;
    if1.StallReq = 0; if1.StallCycles = 0; if1.FlushReq = 0; if1.BusyReq = 0;
    if2.StallReq = 0; if2.StallCycles = 0; if2.FlushReq = 0; if2.BusyReq = 0;
    sc_en = 0; sc_load = 0; sc_load_value = 0;

    // reset held two cycles; a stall request during reset must not show
    step(1, 0, 0, 0, 0); chk("reset_c1", o1(), {V_N, 2'd0});
    step(1, 1, 2, 1, 0); chk("reset_c2_req", o1(), {V_N, 2'd0});
    step(0, 0, 0, 0, 0); chk("post_reset", o1(), {V_N, 2'd0});

    // two-cycle stall
    step(0, 1, 2, 0, 0); chk("st2_c1", o1(), {V_S, 2'd0});
    step(0, 0, 0, 0, 0); chk("st2_c2", o1(), {V_S, 2'd1});
    step(0, 0, 0, 0, 0); chk("st2_done", o1(), {V_N, 2'd0});

    // zero length behaves as one
    step(0, 1, 0, 0, 0); chk("st0_c1", o1(), {V_S, 2'd0});
    step(0, 0, 0, 0, 0); chk("st0_done", o1(), {V_N, 2'd0});

    // three cycles; MAX_STALL=2 instance clamps to two
    step(0, 1, 3, 0, 0); chk("st3_c1", o1(), {V_S, 2'd0}); chk("clamp_c1", o2(), {V_S, 2'd0});
    step(0, 0, 0, 0, 0); chk("st3_c2", o1(), {V_S, 2'd1}); chk("clamp_c2", o2(), {V_S, 2'd1});
    step(0, 0, 0, 0, 0); chk("st3_c3", o1(), {V_S, 2'd1}); chk("clamp_done", o2(), {V_N, 2'd0});
    step(0, 0, 0, 0, 0); chk("st3_done", o1(), {V_N, 2'd0});

    // flush aborts a running stall
    step(0, 1, 3, 0, 0); chk("abort_c1", o1(), {V_S, 2'd0});
    step(0, 0, 0, 1, 0); chk("abort_flush", o1(), {V_F, 2'd1});
    step(0, 0, 0, 0, 0); chk("abort_after", o1(), {V_N, 2'd0});

    // busy freezes a stall, then the count resumes
    step(0, 1, 3, 0, 0); chk("resume_c1", o1(), {V_S, 2'd0});
    step(0, 0, 0, 0, 1); chk("resume_hold", o1(), {V_S, 2'd1});
    step(0, 0, 0, 0, 0); chk("resume_c2", o1(), {V_S, 2'd2});
    step(0, 0, 0, 0, 0); chk("resume_c3", o1(), {V_S, 2'd1});
    step(0, 0, 0, 0, 0); chk("resume_done", o1(), {V_N, 2'd0});

    // flush and stall in the same cycle: stall dropped
    step(0, 1, 2, 1, 0); chk("fl_st_same", o1(), {V_F, 2'd0});
    step(0, 0, 0, 0, 0); chk("fl_st_after", o1(), {V_N, 2'd0});

    // held request re-triggers once the previous stall completes
    step(0, 1, 2, 0, 0); chk("retrig_c1", o1(), {V_S, 2'd0});
    step(0, 1, 2, 0, 0); chk("retrig_c2", o1(), {V_S, 2'd1});
    step(0, 1, 2, 0, 0); chk("retrig_c3", o1(), {V_S, 2'd0});
    step(0, 0, 0, 0, 0); chk("retrig_c4", o1(), {V_S, 2'd1});
    step(0, 0, 0, 0, 0); chk("retrig_done", o1(), {V_N, 2'd0});

    // busy + pending flush beats remaining stall
    step(1, 0, 0, 0, 0); chk("rst2", o1(), {V_N, 2'd0});
    step(0, 1, 3, 0, 0); chk("pend_c1", o1(), {V_S, 2'd0});
    step(0, 0, 0, 0, 1); chk("pend_c2", o1(), {V_S, 2'd1});
    step(0, 0, 0, 1, 1); chk("pend_c3", o1(), {V_S, 2'd2});
    step(0, 0, 0, 0, 1); chk("pend_c4", o1(), {V_S, 2'd2});
    step(0, 0, 0, 0, 0); chk("pend_c5", o1(), {V_F, 2'd2});
    step(0, 0, 0, 0, 0); chk("pend_c6", o1(), {V_N, 2'd0});
`ifdef STALL_PERF_CNT_EN
    chk("perf_stall", if1.StallCount, 32'd1);
    chk("perf_hold",  if1.HoldCount,  32'd3);
    chk("perf_flush", if1.FlushCount, 32'd1);
`endif

    // busy in IDLE with a stall request: hold, then the request is evaluated
    step(0, 1, 1, 0, 1); chk("idle_busy", o1(), {V_S, 2'd0});
    step(0, 1, 1, 0, 0); chk("idle_busy_rel", o1(), {V_S, 2'd2});
    step(0, 0, 0, 0, 0); chk("idle_busy_done", o1(), {V_N, 2'd0});

    // saturating counter preset near max
    chk("sat_reset", sc_count, 32'd0);
    @(posedge Clk); #1; sc_load = 1; sc_load_value = 32'hFFFF_FFFD;
    @(posedge Clk); #1; sc_load = 0; sc_en = 1;
    @(negedge Clk); chk("sat_loaded", sc_count, 32'hFFFF_FFFD);
    @(posedge Clk); #1;
    @(negedge Clk); chk("sat_inc1", sc_count, 32'hFFFF_FFFE);
    repeat (4) @(posedge Clk);
    #1; sc_en = 0;
    @(negedge Clk); chk("sat_hold_max", sc_count, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Sequences the pipeline-control outputs PCWrite, IFIDWrite, IDStall and IF_Flush.
- Turns single-cycle hazard requests into timed stall, hold and flush sequences:
  - multi-cycle load-use and branch stalls,
  - branch-taken flush,
  - whole-pipeline freeze while a multi-cycle unit (e.g. SAD/sum cache) is busy.
- Sits between the combinational hazard detector and the PC/IFID/IDEX registers. It is the single owner of these four control lines.

Parameters:
- MAX_STALL, 3, largest legal stall length in cycles; larger requests are clamped to this value.
- CNT_W, 2, width of StallCycles and of the internal remaining-cycle counter; must satisfy 2^CNT_W > MAX_STALL.

Ports:
- Clk  input  1  core clock
- Reset  input  1  synchronous, active-high reset
- StallReq  input  1  hazard detector requests a stall of the instruction in ID
- StallCycles  input  CNT_W  requested stall length; 0 is treated as 1
- FlushReq  input  1  branch resolved taken (PCSRC); flush IF
- BusyReq  input  1  level; a multi-cycle unit is busy and the pipeline must freeze
- PCWrite  output  1  PC register write enable
- IFIDWrite  output  1  IF/ID register write enable
- IDStall  output  1  insert a nop into ID/EX
- IF_Flush  output  1  zero the IF/ID instruction
- State  output  2  current state: IDLE=0, STALL=1, HOLD=2

Behaviour:
- One clock, Clk; Reset is synchronous and active-high.
- Reset:
  - state=IDLE, remaining counter=0, pending-flush=0.
  - Outputs during and after reset: PCWrite=1, IFIDWrite=1, IDStall=0, IF_Flush=0, State=0.
- Output encodings:
  - Normal: PCWrite=1, IFIDWrite=1, IDStall=0, IF_Flush=0.
  - Stall: PCWrite=0, IFIDWrite=0, IDStall=1, IF_Flush=0.
  - Hold: PCWrite=0, IFIDWrite=0, IDStall=1, IF_Flush=0.
  - Flush: PCWrite=1, IFIDWrite=1, IDStall=1, IF_Flush=1.
- Outputs are Mealy in IDLE, so a request takes effect in the same cycle (zero latency).
- Priority within a cycle: Reset > BusyReq > FlushReq/pending-flush > STALL continuation > StallReq.
- IDLE:
  - BusyReq=1: Hold outputs; if FlushReq=1, set pending-flush; go to HOLD.
  - Else FlushReq=1 or pending-flush=1: Flush outputs for this cycle; clear pending-flush; stay IDLE. Any StallReq in the same cycle is dropped.
  - Else StallReq=1: Stall outputs. Let N = clamp(max(StallCycles,1), MAX_STALL).
    - N==1: stay IDLE.
    - Otherwise: load remaining=N-1 and go to STALL.
  - Else: Normal outputs.
- STALL:
  - Stall outputs every cycle; remaining decrements each cycle; StallReq is ignored.
  - At remaining==1 the next state is IDLE. Total stall cycles is exactly N.
  - FlushReq=1: Flush outputs this cycle; abort the stall; remaining=0; next state IDLE.
  - BusyReq=1: go to HOLD; remaining is preserved.
- HOLD:
  - Hold outputs while BusyReq=1; FlushReq arriving here sets pending-flush.
  - When BusyReq drops:
    - remaining>0: return to STALL; that cycle shows Stall outputs and the count resumes.
    - Otherwise: return to IDLE and evaluate IDLE rules in that cycle. Pending-flush therefore fires in the first non-busy cycle.
- After a STALL completes, IDLE re-evaluates StallReq. A still-asserted request starts a new sequence, which is intended: the hazard detector is the authority.
- No combinational path from outputs back to inputs; the counter never wraps.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined:
  - Adds outputs StallCount[31:0], HoldCount[31:0] and FlushCount[31:0], each zeroed by Reset.
  - Each increments by 1 on every cycle whose outputs are Stall, Hold or Flush respectively.
  - Each saturates at 32'hFFFFFFFF.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encodings IDLE/STALL/HOLD;
  - constants for the Normal, Stall, Hold and Flush output vectors {PCWrite, IFIDWrite, IDStall, IF_Flush};
  - default MAX_STALL.
- One natural sub-module: sat_counter32 (enable, synchronous reset, saturating), instantiated three times under STALL_PERF_CNT_EN.

Test Plan:
- Reset held 2 cycles, then released with no requests -> outputs 1,1,0,0; State=0.
- StallReq=1 for 1 cycle, StallCycles=2 -> exactly 2 consecutive Stall cycles (State 0 then 1), then Normal.
- StallCycles=0 -> exactly 1 stall cycle. StallCycles=3 with MAX_STALL=2 -> exactly 2 stall cycles.
- StallCycles=3, FlushReq in the 2nd cycle -> that cycle shows Flush 1,1,1,1; next cycle Normal with State=0.
- StallCycles=3, BusyReq high in cycles 2-4, FlushReq pulsed in cycle 3 -> cycles 2-4 Hold; cycle 5 Flush (flush beats the remaining stall, so remaining is discarded); cycle 6 Normal.
- With STALL_PERF_CNT_EN: scenario above -> StallCount=1, HoldCount=3, FlushCount=1. Counter preset near max then 5 increments -> stays at 32'hFFFFFFFF.
